td_tdc: RTL and testbench



---
 rtl/td_tdc_pkg.sv | 14 +
 rtl/td_sync.sv | 20 ++
 rtl/td_tdc.sv | 132 +++++++++++++
 tb/tb_td_tdc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/td_tdc_pkg.sv
// Shared types and constants for the time-to-digital converter.
package td_tdc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_WIDTH = 1'b1;

endpackage

// File: rtl/td_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module td_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/td_tdc.sv
// Time-to-digital converter: counts cycles to a rising edge or across a high pulse.
// Optional sticky overrun flag for ignored starts under TD_TDC_OVERRUN_EN.
module td_tdc
  import td_tdc_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             y_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] result_o,
  output logic             timeout_o
`ifdef TD_TDC_OVERRUN_EN
  ,
  output logic             overrun_o
`endif
);

  // Result handshake: result_o/timeout_o are valid while valid_o=1 and are
  // consumed on a cycle with valid_o && ready_i; they hold until then.
  localparam logic [CNT_W-1:0] SYNC_LAT = CNT_W'(SYNC_STAGES - 1);

  logic             y_s;
  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] result_q;
  logic             valid_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] edge_res_d;
  logic             cnt_max;

  td_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (y_i),
    .q_o (y_s)
  );

  // Remove the synchronizer delay so an edge sampled at Ek reports k.
  assign edge_res_d = (cnt_q > SYNC_LAT) ? cnt_q - SYNC_LAT : '0;
  assign cnt_max    = (cnt_q == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_EDGE;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (y_s) begin
            if (mode_q == MODE_EDGE) begin
              result_q <= edge_res_d;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q   <= CNT_W'(1);
              state_q <= WAIT_FALL;
            end
          end else if (cnt_max) begin
            result_q  <= '1;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_FALL: begin
          if (!y_s) begin
            result_q <= cnt_q;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else if (cnt_max) begin
            result_q  <= '1;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TD_TDC_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (rst)                  overrun_q <= 1'b0;
    else if (start_i && busy_q) overrun_q <= 1'b1;
  end

  assign overrun_o = overrun_q;
`endif

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_td_tdc.sv
// Self-checking bench for td_tdc: directed vector table, hand sequences, random runs.
module tb_td_tdc;

  localparam int CNT_W = 4;
  localparam int SYNC  = 2;
  localparam int MAX   = (1 << CNT_W) - 1;
  localparam int NEVER = 999;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             mode_i = 1'b0;
  logic             y_i = 1'b0;
  logic             ready_i = 1'b0;
  logic             busy_o;
  logic             valid_o;
  logic [CNT_W-1:0] result_o;
  logic             timeout_o;
`ifdef TD_TDC_OVERRUN_EN
  logic             overrun_o;
`endif
  bit               exp_ovr = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [CNT_W:0] exp_q[$];

  typedef struct {
    bit mode;
    int k;
    int w;
    int hold;
    bit bstart;
    int res;
    bit to;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  td_tdc #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .y_i       (y_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .timeout_o (timeout_o)
`ifdef TD_TDC_OVERRUN_EN
    ,
    .overrun_o (overrun_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ovr(input string name);
`ifdef TD_TDC_OVERRUN_EN
    chk({name, "_overrun"}, overrun_o, exp_ovr);
`endif
  endtask

  // Reference: k = first edge y_i is sampled high (k<=0 means already high),
  // w = number of edges it stays high. det = edge after which valid_o rises.
  function automatic void model(input bit m, input int k, input int w,
                                output int res, output bit to, output int det);
    int r;
    r = (k <= 0) ? 1 : k + SYNC;
    if (r - 1 > MAX) begin
      res = MAX; to = 1'b1; det = MAX + 1;
    end else if (!m) begin
      res = (k <= 0) ? 0 : k; to = 1'b0; det = r;
    end else if (w > MAX) begin
      res = MAX; to = 1'b1; det = r + MAX;
    end else begin
      res = w; to = 1'b0; det = r + w;
    end
  endfunction

  function automatic bit y_at(input bit m, input int k, input int w, input int e);
    if (k <= 0) return 1'b1;
    if (!m)     return (e >= k);
    return (e >= k) && (e < k + w);
  endfunction

  // Entered and left at #1 after a posedge with y_i idle low.
  task automatic run_meas(input bit m, input int k, input int w, input int hold,
                          input bit bstart, input int exp_res, input bit exp_to,
                          input int exp_det, input string tag);
    int e;
    bit seen;
    logic [CNT_W:0] item;
    seen = 1'b0;
    if (k <= 0) begin
      y_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
    start_i = 1'b1;
    mode_i  = m;
    exp_q.push_back({exp_to, CNT_W'(exp_res)});
    for (e = 0; e < 60; e++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      start_i = 1'b0;
      if (bstart && e == 2) begin
        start_i = 1'b1;
        mode_i  = ~m;
        exp_ovr = 1'b1;
      end
      y_i = y_at(m, k, w, e + 1);
    end
    start_i = 1'b0;
    y_i     = 1'b0;
    item    = exp_q.pop_front();
    if (!seen) begin
      chk({tag, "_no_valid"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, e, exp_det);
    chk({tag, "_result"}, result_o, item[CNT_W-1:0]);
    chk({tag, "_timeout"}, timeout_o, item[CNT_W]);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, valid_o, 1);
      chk({tag, "_hold_busy"}, busy_o, 1);
      chk({tag, "_hold_result"}, result_o, item[CNT_W-1:0]);
    end
    ready_i = 1'b1;
    if (bstart) begin
      start_i = 1'b1;
      exp_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    start_i = 1'b0;
    chk({tag, "_acc_valid"}, valid_o, 0);
    chk({tag, "_acc_busy"}, busy_o, 0);
    chk({tag, "_acc_timeout"}, timeout_o, 0);
    chk_ovr(tag);
    repeat (SYNC + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int res, det, k, w, vhigh;
    bit to, m;

    tbl[0]  = '{1'b0, 5,     0,  0, 1'b0, 5,  1'b0};
    tbl[1]  = '{1'b1, 3,     7,  0, 1'b0, 7,  1'b0};
    tbl[2]  = '{1'b0, NEVER, 0,  0, 1'b0, 15, 1'b1};
    tbl[3]  = '{1'b0, 5,     0,  4, 1'b1, 5,  1'b0};
    tbl[4]  = '{1'b0, -3,    0,  0, 1'b0, 0,  1'b0};
    tbl[5]  = '{1'b1, 1,     15, 0, 1'b0, 15, 1'b0};
    tbl[6]  = '{1'b1, 1,     16, 1, 1'b0, 15, 1'b1};
    tbl[7]  = '{1'b0, 14,    0,  0, 1'b0, 14, 1'b0};
    tbl[8]  = '{1'b0, 15,    0,  2, 1'b0, 15, 1'b1};
    tbl[9]  = '{1'b1, NEVER, 3,  0, 1'b1, 15, 1'b1};
    tbl[10] = '{1'b0, 1,     0,  0, 1'b0, 1,  1'b0};
    tbl[11] = '{1'b1, 1,     1,  3, 1'b1, 1,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_result", result_o, 0);
    chk("reset_timeout", timeout_o, 0);
    chk_ovr("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].mode, tbl[i].k, tbl[i].w, res, to, det);
      run_meas(tbl[i].mode, tbl[i].k, tbl[i].w, tbl[i].hold, tbl[i].bstart,
               tbl[i].res, tbl[i].to, det, $sformatf("vec%0d", i));
    end

    // Reset while the pulse is being timed (rise seen at E4).
    start_i = 1'b1;
    mode_i  = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      y_i = ((e + 1) >= 2) && ((e + 1) < 12);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    y_i     = 1'b0;
    exp_ovr = 1'b0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_timeout", timeout_o, 0);
    chk_ovr("midrst");
    vhigh = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid_o || busy_o) vhigh++;
    end
    chk("midrst_quiet", vhigh, 0);
    model(1'b1, 2, 6, res, to, det);
    run_meas(1'b1, 2, 6, 0, 1'b0, 6, 1'b0, det, "after_rst");

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 17));
      w = int'($urandom_range(1, 17));
      model(m, k, w, res, to, det);
      run_meas(m, k, w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               res, to, det, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
